scan_flop_bank: RTL and testbench

- Parametrised successor to the single-bit falling-edge scan flop cell: a WIDTH-bit bank of scan flops sharing one clock, one reset and one scan chain.
- Adds per-bank parallel capture enable, selectable scan direction, a shift-length counter with a chain-complete flag, and a sticky timing-violation flag fed by the timing-check notifier.
- Sits in the cell-model layer; higher-level scan chains instantiate it in place of discrete scan flops.

---
 rtl/scan_flop_bank.sv | 104 ++++++++++
 tb/tb_scan_flop_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scan_flop_bank.sv
// -----------------------------------------------------------------------------
// scan_flop_bank
//   WIDTH-bit bank of falling-edge scan flops sharing one clock, one reset and
//   one scan chain. Adds parallel capture enable, selectable scan direction,
//   a saturating shift-length counter with chain-complete flag, and a sticky
//   timing-violation flag driven by the timing-check notifier.
//
// Ports
//   CKN        in   clock, all state updates on its falling edge
//   RD         in   synchronous active-high reset
//   D          in   parallel capture data (WIDTH)
//   EN         in   parallel capture enable
//   SE         in   scan enable (wins over EN)
//   SI         in   scan input
//   NTF        in   timing-check notifier, any level change is a violation
//   Q          out  bank state (WIDTH)
//   SO         out  scan output, combinational from Q
//   SHIFT_CNT  out  consecutive shift count, saturates at WIDTH (CW)
//   SHIFT_DONE out  SHIFT_CNT == WIDTH
//   VIOL       out  sticky violation flag, cleared only by RD
// -----------------------------------------------------------------------------
module scan_flop_bank #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RST_VAL        = '0,
  parameter bit               SCAN_LSB_FIRST = 1'b1,
  localparam int              CW             = $clog2(WIDTH + 1)
) (
  input  logic             CKN,
  input  logic             RD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
  input  logic             NTF,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [CW-1:0]    SHIFT_CNT,
  output logic             SHIFT_DONE,
  output logic             VIOL
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             viol_q, viol_d;
  logic             ntf_q;

  // One scan step in the configured direction.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] q,
                                                input logic si);
    logic [WIDTH-1:0] r;
    if (SCAN_LSB_FIRST) r = {si, q[WIDTH-1:1]};
    else                r = {q[WIDTH-2:0], si};
    return r;
  endfunction

  // Shift count saturates at WIDTH rather than wrapping, so SHIFT_DONE
  // stays asserted while SE is held past a full chain.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    if (c == CNT_MAX) r = c;
    else              r = c + 1'b1;
    return r;
  endfunction

  // Next-state: shift > capture > hold; counter restarts on any SE=0 edge.
  always_comb begin
    q_d    = q_q;
    cnt_d  = '0;
    viol_d = viol_q;
    if (SE) begin
      q_d   = shift_in(q_q, SI);
      cnt_d = sat_inc(cnt_q);
    end else if (EN) begin
      q_d = D;
    end
    // A violation never touches Q; it only raises the sticky flag.
    if (NTF != ntf_q) viol_d = 1'b1;
  end

  // Falling-edge state update; reset overrides everything on its edge.
  always_ff @(negedge CKN) begin
    // The notifier copy is refreshed on every edge, including reset, so the
    // first edge after reset never reports a stale level change.
    ntf_q <= NTF;
    if (RD) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      viol_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      viol_q <= viol_d;
    end
  end

  assign Q          = q_q;
  assign SO         = SCAN_LSB_FIRST ? q_q[0] : q_q[WIDTH-1];
  assign SHIFT_CNT  = cnt_q;
  assign SHIFT_DONE = (cnt_q == CNT_MAX);
  assign VIOL       = viol_q;

endmodule

// File: tb/tb_scan_flop_bank.sv
module tb_scan_flop_bank;

  localparam int         W   = 8;
  localparam logic [7:0] RST = 8'hA5;

  logic       CKN;
  logic       RD, EN, SE, SI, NTF;
  logic [7:0] D;
  logic [7:0] q0, q1;
  logic       so0, so1, done0, done1, viol0, viol1;
  logic [3:0] cnt0, cnt1;

  // LSB-first bank
  scan_flop_bank #(.WIDTH(W), .RST_VAL(RST), .SCAN_LSB_FIRST(1'b1)) dut0 (
    .CKN(CKN), .RD(RD), .D(D), .EN(EN), .SE(SE), .SI(SI), .NTF(NTF),
    .Q(q0), .SO(so0), .SHIFT_CNT(cnt0), .SHIFT_DONE(done0), .VIOL(viol0));

  // MSB-first bank sharing all inputs
  scan_flop_bank #(.WIDTH(W), .RST_VAL(RST), .SCAN_LSB_FIRST(1'b0)) dut1 (
    .CKN(CKN), .RD(RD), .D(D), .EN(EN), .SE(SE), .SI(SI), .NTF(NTF),
    .Q(q1), .SO(so1), .SHIFT_CNT(cnt1), .SHIFT_DONE(done1), .VIOL(viol1));

  initial CKN = 1'b1;
  always #5 CKN = ~CKN;

  typedef struct {
    logic [7:0] q0, q1;
    logic       so0, so1;
    int         cnt;
    logic       done;
    logic       viol;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (value after the most recent falling edge)
  logic [7:0] m_q0, m_q1;
  int         m_cnt;
  logic       m_viol, m_ntf;
  logic       cur_ntf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one edge worth of inputs and push the model's post-edge state.
  task automatic step(input logic rd, input logic se, input logic en,
                      input logic [7:0] d, input logic si, input logic tog);
    exp_t e;
    @(posedge CKN);
    if (tog) cur_ntf = ~cur_ntf;
    RD = rd; SE = se; EN = en; D = d; SI = si; NTF = cur_ntf;
    if (rd) begin
      m_q0 = RST; m_q1 = RST; m_cnt = 0; m_viol = 1'b0;
    end else begin
      if (se) begin
        m_q0  = (m_q0 >> 1) | (8'(si) << 7);
        m_q1  = 8'((m_q1 << 1) | 8'(si));
        m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
      end else begin
        m_cnt = 0;
        if (en) begin m_q0 = d; m_q1 = d; end
      end
      if (cur_ntf != m_ntf) m_viol = 1'b1;
    end
    m_ntf  = cur_ntf;
    e.q0   = m_q0;
    e.q1   = m_q1;
    e.so0  = m_q0[0];
    e.so1  = m_q1[7];
    e.cnt  = m_cnt;
    e.done = (m_cnt == W);
    e.viol = m_viol;
    exp_q.push_back(e);
  endtask

  // Monitor: every falling edge the banks present a new state.
  always @(negedge CKN) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("q_lsb",    64'(q0),    64'(e.q0));
      chk("q_msb",    64'(q1),    64'(e.q1));
      chk("so_lsb",   64'(so0),   64'(e.so0));
      chk("so_msb",   64'(so1),   64'(e.so1));
      chk("cnt_lsb",  64'(cnt0),  64'(e.cnt));
      chk("cnt_msb",  64'(cnt1),  64'(e.cnt));
      chk("done_lsb", 64'(done0), 64'(e.done));
      chk("done_msb", 64'(done1), 64'(e.done));
      chk("viol_lsb", 64'(viol0), 64'(e.viol));
      chk("viol_msb", 64'(viol1), 64'(e.viol));
    end
  end

  task automatic settle();
    @(negedge CKN);
    #3;
  endtask

  logic [7:0] si_seq;

  initial begin
    RD = 1'b1; SE = 1'b0; EN = 1'b0; D = '0; SI = 1'b0; NTF = 1'b0;
    cur_ntf = 1'b0; m_ntf = 1'b0;
    m_q0 = RST; m_q1 = RST; m_cnt = 0; m_viol = 1'b0;

    // Reset for two edges
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    settle();
    chk("rst_q",    64'(q0),    64'hA5);
    chk("rst_so",   64'(so0),   64'h1);
    chk("rst_cnt",  64'(cnt0),  64'h0);
    chk("rst_done", 64'(done0), 64'h0);
    chk("rst_viol", 64'(viol0), 64'h0);

    // Capture, hold, shift-over-capture
    step(0, 0, 1, 8'h3C, 0, 0);
    settle();
    chk("cap_q", 64'(q0), 64'h3C);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'hFF, 0, 0);
    settle();
    chk("hold_q", 64'(q0), 64'h3C);
    step(0, 1, 1, 8'h00, 1, 0);
    settle();
    chk("shift_prio_q", 64'(q0), 64'h9E);

    // Full chain from 3C with SI 1,0,1,1,0,0,1,0
    step(0, 0, 1, 8'h3C, 0, 0);
    si_seq = 8'b0100_1101;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00, si_seq[i], 0);
    settle();
    chk("chain_q",    64'(q0),    64'h4D);
    chk("chain_cnt",  64'(cnt0),  64'h8);
    chk("chain_done", 64'(done0), 64'h1);
    step(0, 1, 0, 8'h00, 1, 0);
    settle();
    chk("chain_sat", 64'(cnt0), 64'h8);

    // Partial shift, restart, full count
    step(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 1'(i), 0);
    settle();
    chk("part_cnt", 64'(cnt0), 64'h5);
    step(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00, 1'(i >> 1), 0);

    // Violation mid-shift, further toggles, reset with toggle
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 1'(i), (i == 2));
    step(0, 1, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    step(1, 1, 1, 8'hFF, 1, 1);
    step(0, 0, 0, 8'h00, 0, 0);

    // Reset at shift edge 4 with SE held
    step(0, 0, 1, 8'h5A, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 1, 0);
    step(1, 1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           8'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CKN);
    #4;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
